// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl
//   Cursor / level-select controller driven by a 4-way key pad and a confirm
//   button. In grid navigation the cursor moves inside a ROWS x COLS grid
//   without wrapping; in level select the keys adjust a pending level that A
//   commits.
//
//   Optional feature: define AUTO_REPEAT_EN to enable key auto-repeat
//   (first repeat after REPEAT_DELAY cycles, then every REPEAT_RATE cycles).
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   keys[3:0]    async keys: bit0 up, bit1 down, bit2 left, bit3 right
//   A            async confirm button
//   inputState   1 = level select, 2 = grid navigation, others = idle
//   cursor_row   current cursor row
//   cursor_col   current cursor column
//   cursor_idx   cursor_row*COLS + cursor_col
//   level        committed level (1..LEVELS)
//   move_pulse   one-cycle strobe when the cursor position changes
//   level_valid  one-cycle strobe when level is committed
module grid_cursor_ctrl #(
    parameter int ROWS         = 6,
    parameter int COLS         = 6,
    parameter int LEVELS       = 4,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      keys,
    input  logic                            A,
    input  logic [2:0]                      inputState,
    output logic [$clog2(ROWS)-1:0]         cursor_row,
    output logic [$clog2(COLS)-1:0]         cursor_col,
    output logic [$clog2(ROWS*COLS)-1:0]    cursor_idx,
    output logic [$clog2(LEVELS+1)-1:0]     level,
    output logic                            move_pulse,
    output logic                            level_valid
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(ROWS*COLS);
    localparam int LW = $clog2(LEVELS+1);

    if (ROWS < 2 || ROWS > 64 || COLS < 2 || COLS > 64 ||
        LEVELS < 2 || LEVELS > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("grid_cursor_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        LEVEL_SEL,
        GRID
    } state_t;

    state_t state, state_next;

    logic [3:0]    keys_s1, keys_s2;
    logic          a_s1, a_s2, a_prev;
    logic [1:0]    sync_fill;
    logic          armed;
    logic          key_onehot;
    logic          press_evt;
    logic          key_evt;
    logic          a_edge;
    logic [LW-1:0] pending;

    logic [RW-1:0] row_step;
    logic [CW-1:0] col_step;
    logic [LW-1:0] pend_step;
    logic          moved;

    // Two-flop synchronizers. sync_fill marks when keys_s2 holds a real
    // sample rather than its reset value, so a key held through reset cannot
    // arm the event path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keys_s1   <= '0;
            keys_s2   <= '0;
            a_s1      <= 1'b0;
            a_s2      <= 1'b0;
            a_prev    <= 1'b0;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            keys_s1   <= keys;
            keys_s2   <= keys_s1;
            a_s1      <= A;
            a_s2      <= a_s1;
            a_prev    <= a_s2;
            sync_fill <= {sync_fill[0], 1'b1};
            // armed == "previous genuine sample was all-released"
            armed     <= sync_fill[1] && (keys_s2 == 4'b0000);
        end
    end

    assign key_onehot = (keys_s2 != 4'b0000) && ((keys_s2 & (keys_s2 - 4'd1)) == 4'b0000);
    assign press_evt  = armed && key_onehot;
    assign a_edge     = a_s2 && !a_prev;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW      = $clog2(RPT_MAX + 1);

    logic [TW-1:0] rpt_cnt;
    logic          rpt_phase;   // 0: waiting first delay, 1: repeating at rate
    logic          rpt_hold;
    logic [3:0]    rpt_keys;
    logic          rpt_evt;

    assign rpt_evt = rpt_hold && (keys_s2 == rpt_keys) &&
                     (rpt_phase ? (rpt_cnt == TW'(REPEAT_RATE - 1))
                                : (rpt_cnt == TW'(REPEAT_DELAY - 1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
            rpt_hold  <= 1'b0;
            rpt_keys  <= '0;
        end else if (press_evt) begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
            rpt_hold  <= 1'b1;
            rpt_keys  <= keys_s2;
        end else if (rpt_hold && (keys_s2 == rpt_keys)) begin
            if (rpt_evt) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_cnt + TW'(1);
            end
        end else begin
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
            rpt_hold  <= 1'b0;
        end
    end

    assign key_evt = press_evt || rpt_evt;
`else
    assign key_evt = press_evt;
`endif

    always_comb begin
        case (inputState)
            3'd1:    state_next = LEVEL_SEL;
            3'd2:    state_next = GRID;
            default: state_next = IDLE;
        endcase
    end

    // Candidate next cursor / pending level for the current key pattern;
    // only consumed on a key event, when keys_s2 is one-hot.
    always_comb begin
        row_step  = cursor_row;
        col_step  = cursor_col;
        pend_step = pending;
        if (keys_s2[0]) begin
            if (cursor_row != '0)         row_step  = cursor_row - RW'(1);
            if (pending != LW'(LEVELS))   pend_step = pending + LW'(1);
        end
        if (keys_s2[1]) begin
            if (cursor_row != RW'(ROWS - 1)) row_step  = cursor_row + RW'(1);
            if (pending != LW'(1))           pend_step = pending - LW'(1);
        end
        if (keys_s2[2]) begin
            if (cursor_col != '0)            col_step  = cursor_col - CW'(1);
        end
        if (keys_s2[3]) begin
            if (cursor_col != CW'(COLS - 1)) col_step  = cursor_col + CW'(1);
        end
        moved = (row_step != cursor_row) || (col_step != cursor_col);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cursor_row  <= '0;
            cursor_col  <= '0;
            level       <= LW'(1);
            pending     <= LW'(1);
            move_pulse  <= 1'b0;
            level_valid <= 1'b0;
        end else begin
            state       <= state_next;
            move_pulse  <= 1'b0;
            level_valid <= 1'b0;

            case (state)
                GRID: begin
                    if (key_evt && moved) begin
                        cursor_row <= row_step;
                        cursor_col <= col_step;
                        move_pulse <= 1'b1;
                    end
                end
                LEVEL_SEL: begin
                    if (key_evt)
                        pending <= pend_step;
                    // Commits the pre-key pending value when both coincide.
                    if (a_edge) begin
                        level       <= pending;
                        level_valid <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Entry actions; state is not GRID/LEVEL_SEL here, so the case
            // above never updated the same registers this cycle.
            if (state_next == GRID && state != GRID) begin
                cursor_row <= '0;
                cursor_col <= '0;
            end
            if (state_next == LEVEL_SEL && state != LEVEL_SEL)
                pending <= level;
        end
    end

    assign cursor_idx = IW'(cursor_row) * IW'(COLS) + IW'(cursor_col);

endmodule
